// File: rtl/cdma_pkg.sv
// rtl/cdma_pkg.sv - shared constants and width helpers for the multi-channel CDMA spreader
package cdma_pkg;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int code_len(input int deg);
        return (1 << deg) - 1;
    endfunction

    // Correlator accumulator: |corr| <= L plus a sign bit and one bit of margin.
    function automatic int acc_width(input int deg);
        return clog2(code_len(deg)) + 2;
    endfunction

    function automatic int sum_width(input int n_ch);
        return clog2(n_ch) + 2;
    endfunction

    // Channel select needs at least one bit even for a single channel.
    function automatic int sel_width(input int n_ch);
        return (clog2(n_ch) > 0) ? clog2(n_ch) : 1;
    endfunction

    // Preferred pair for degree 5: x^5+x^2+1 and x^5+x^3+x^2+x+1.
    localparam logic [4:0] POLY_A_DEF = 5'b00101;
    localparam logic [4:0] POLY_B_DEF = 5'b01111;

    localparam int DEG_DEF   = 5;
    localparam int N_CH_DEF  = 4;
    localparam int L_DEF     = code_len(DEG_DEF);
    localparam int ACC_W_DEF = acc_width(DEG_DEF);
    localparam int SUM_W_DEF = sum_width(N_CH_DEF);

endpackage

// File: rtl/gold_lfsr.sv
// rtl/gold_lfsr.sv - Fibonacci-style LFSR used as one half of a Gold code generator
module gold_lfsr #(
    parameter int             DEG      = 5,
    parameter logic [DEG-1:0] POLY     = DEG'(5'b00101),
    parameter logic [DEG-1:0] RST_SEED = '1
) (
    input  logic           clk_i,
    input  logic           set_i,
    input  logic           load_i,
    input  logic [DEG-1:0] seed_i,
    input  logic           step_i,
    output logic           bit_o
);

    logic [DEG-1:0] s_q;
    logic [DEG-1:0] s_d;
    logic           fb;

    // Next state: a reseed wins over a step; the feedback bit enters at the MSB.
    always_comb begin
        fb  = ^(s_q & POLY);
        s_d = s_q;
        if (load_i) begin
            s_d = seed_i;
        end else if (step_i) begin
            s_d = {fb, s_q[DEG-1:1]};
        end
    end

    // State register with asynchronous return to the reset seed.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            s_q <= RST_SEED;
        end else begin
            s_q <= s_d;
        end
    end

    assign bit_o = s_q[0];

endmodule

// File: rtl/cdma_multi.sv
// rtl/cdma_multi.sv - multi-channel Gold-code spreader with a single-channel correlating receiver
module cdma_multi
    import cdma_pkg::*;
#(
    parameter int             DEG    = DEG_DEF,
    parameter logic [DEG-1:0] POLY_A = DEG'(POLY_A_DEF),
    parameter logic [DEG-1:0] POLY_B = DEG'(POLY_B_DEF),
    parameter int             N_CH   = N_CH_DEF,
    parameter int             DIV    = 10_000_000,
    parameter int             THRESH = 24
) (
    input  logic                              clk_i,
    input  logic                              set_i,
    input  logic                              load_i,
    input  logic [DEG-1:0]                    seed_i,
    input  logic [N_CH-1:0]                   data_i,
    input  logic                              rx_i,
    input  logic [sel_width(N_CH)-1:0]        rx_sel_i,
    output logic [N_CH-1:0]                   chip_o,
    output logic [N_CH-1:0]                   gold_o,
    output logic signed [sum_width(N_CH)-1:0] sum_o,
    output logic                              rx_bit_o,
    output logic                              rx_valid_o,
    output logic                              lock_o,
    output logic                              sym_o
);

    localparam int L      = code_len(DEG);
    localparam int ACC_W  = acc_width(DEG);
    localparam int SUM_W  = sum_width(N_CH);
    localparam int SEL_W  = sel_width(N_CH);
    localparam int PAD    = 1 << SEL_W;
    localparam int CNT_W  = clog2(L);
    localparam int PCNT_W = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(L - 1);

    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]        chip_cnt_q, chip_cnt_d;
    logic [N_CH-1:0]         data_q, data_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sym_q, sym_d;
    logic                    rx_bit_q, rx_bit_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    lock_q, lock_d;

    logic                    tick;
    logic                    boundary;
    logic                    a_bit;
    logic [N_CH-1:0]         b_bits;
    logic [PAD-1:0]          gold_pad;
    logic                    sel_gold;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] corr;
    logic signed [ACC_W-1:0] corr_abs;
    logic [SUM_W-1:0]        ones;

    assign tick     = (pcnt_q == PCNT_MAX);
    assign boundary = tick && (chip_cnt_q == CNT_MAX);

    gold_lfsr #(.DEG(DEG), .POLY(POLY_A), .RST_SEED('1)) u_lfsr_a (
        .clk_i  (clk_i),
        .set_i  (set_i),
        .load_i (load_i),
        .seed_i ('1),
        .step_i (tick),
        .bit_o  (a_bit)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DEG-1:0] seed_raw;
        logic [DEG-1:0] seed_k;
        // A zero seed would lock the LFSR, so it is replaced by all-ones.
        assign seed_raw = seed_i + DEG'(k);
        assign seed_k   = (seed_raw == '0) ? '1 : seed_raw;

        gold_lfsr #(.DEG(DEG), .POLY(POLY_B), .RST_SEED(DEG'(k + 1))) u_lfsr_b (
            .clk_i  (clk_i),
            .set_i  (set_i),
            .load_i (load_i),
            .seed_i (seed_k),
            .step_i (tick),
            .bit_o  (b_bits[k])
        );
    end

    assign gold_o   = {N_CH{a_bit}} ^ b_bits;
    assign chip_o   = data_q ^ gold_o;
    assign gold_pad = PAD'(gold_o);
    assign sel_gold = gold_pad[sel_q];

    // Signed chip sum: 2*popcount - N_CH, computed modulo the output width.
    always_comb begin
        ones = '0;
        for (int k = 0; k < N_CH; k++) begin
            ones = ones + SUM_W'(chip_o[k]);
        end
        sum_o = $signed((ones << 1) - SUM_W'(N_CH));
    end

    // Prescaler, chip counter, symbol latches and correlator next-state.
    always_comb begin
        term       = (rx_i == sel_gold) ? ACC_W'(1) : '1;
        corr       = acc_q + term;
        corr_abs   = corr[ACC_W-1] ? -corr : corr;
        pcnt_d     = tick ? '0 : pcnt_q + PCNT_W'(1);
        chip_cnt_d = chip_cnt_q;
        data_d     = data_q;
        sel_d      = sel_q;
        acc_d      = acc_q;
        sym_d      = sym_q;
        rx_bit_d   = rx_bit_q;
        lock_d     = lock_q;
        rx_valid_d = 1'b0;
        if (load_i) begin
            pcnt_d     = '0;
            chip_cnt_d = '0;
            acc_d      = '0;
            data_d     = data_i;
            sel_d      = rx_sel_i;
        end else if (tick) begin
            if (boundary) begin
                chip_cnt_d = '0;
                acc_d      = '0;
                data_d     = data_i;
                sel_d      = rx_sel_i;
                sym_d      = ~sym_q;
                rx_bit_d   = corr[ACC_W-1];
                lock_d     = (int'(corr_abs) >= THRESH);
                rx_valid_d = 1'b1;
            end else begin
                chip_cnt_d = chip_cnt_q + CNT_W'(1);
                acc_d      = corr;
            end
        end
    end

    // All control and receiver state, asynchronously cleared.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            pcnt_q     <= '0;
            chip_cnt_q <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            acc_q      <= '0;
            sym_q      <= 1'b0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            chip_cnt_q <= chip_cnt_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            acc_q      <= acc_d;
            sym_q      <= sym_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
            lock_q     <= lock_d;
        end
    end

    assign rx_bit_o   = rx_bit_q;
    assign rx_valid_o = rx_valid_q;
    assign lock_o     = lock_q;
    assign sym_o      = sym_q;

endmodule
